// File: rtl/osc_plot_pkg.sv
// rtl/osc_plot_pkg.sv - shared constants and state type for the oscillator trace plotter
package osc_plot_pkg;

   localparam int FIX_W    = 18;
   localparam int FIX_FRAC = 16;

   localparam int H_RES_DEF       = 640;
   localparam int V_RES_DEF       = 480;
   localparam int Y_CENTER_DEF    = 240;
   localparam int Y_GAIN_LOG2_DEF = 7;

   localparam logic [7:0] RGB332_RED   = 8'hE0;
   localparam logic [7:0] RGB332_GREEN = 8'h1C;
   localparam logic [7:0] RGB332_BLACK = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE1,
      ST_ERASE2,
      ST_DRAW1,
      ST_DRAW2,
      ST_ADVANCE
   } plot_state_t;

endpackage

// File: rtl/fix_to_row.sv
// rtl/fix_to_row.sv - maps a signed 2.16 sample to a saturated screen row
module fix_to_row
   import osc_plot_pkg::*;
#(
   parameter int V_RES       = V_RES_DEF,
   parameter int Y_CENTER    = Y_CENTER_DEF,
   parameter int Y_GAIN_LOG2 = Y_GAIN_LOG2_DEF
) (
   input  logic signed [FIX_W-1:0] x,
   output logic        [8:0]       row
);

   logic signed [11:0] t;
   logic signed [11:0] row_s;

   // Arithmetic shift floors toward -inf; screen rows grow downward, hence the subtraction.
   assign t     = 12'(x >>> (FIX_FRAC - Y_GAIN_LOG2));
   assign row_s = $signed(12'(Y_CENTER)) - t;

   always_comb begin
      row = row_s[8:0];
      if (row_s < 0)
         row = '0;
      else if (row_s > $signed(12'(V_RES - 1)))
         row = 9'(V_RES - 1);
   end

endmodule

// File: rtl/osc_trace_plotter.sv
// rtl/osc_trace_plotter.sv - scrolling two-trace plotter; define PLOT_ERASE_EN for row memory and erase pass
module osc_trace_plotter
   import osc_plot_pkg::*;
#(
   parameter int         H_RES       = H_RES_DEF,
   parameter int         V_RES       = V_RES_DEF,
   parameter int         Y_CENTER    = Y_CENTER_DEF,
   parameter int         Y_GAIN_LOG2 = Y_GAIN_LOG2_DEF,
   parameter int         DECIM       = 1,
   parameter logic [7:0] COLOR1      = RGB332_RED,
   parameter logic [7:0] COLOR2      = RGB332_GREEN,
   parameter logic [7:0] COLOR_BG    = RGB332_BLACK
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    smp_valid,
   output logic                    smp_ready,
   input  logic signed [FIX_W-1:0] x1,
   input  logic signed [FIX_W-1:0] x2,
   output logic                    vga_req,
   input  logic                    vga_ack,
   output logic        [9:0]       vga_x,
   output logic        [8:0]       vga_y,
   output logic        [7:0]       vga_color,
   output logic        [9:0]       vga_xCoord
);

   plot_state_t state, state_nxt;
   logic [9:0]  dec_cnt;
   logic [8:0]  row1, row2, y1_q, y2_q, y1_nxt;
   logic [17:0] prev_rows;
   logic        xfer, plot, ack_ok, at_right_edge;

   fix_to_row #(.V_RES(V_RES), .Y_CENTER(Y_CENTER), .Y_GAIN_LOG2(Y_GAIN_LOG2))
      u_row1 (.x(x1), .row(row1));
   fix_to_row #(.V_RES(V_RES), .Y_CENTER(Y_CENTER), .Y_GAIN_LOG2(Y_GAIN_LOG2))
      u_row2 (.x(x2), .row(row2));

   assign xfer          = smp_valid & smp_ready;
   assign plot          = xfer && (dec_cnt == 10'(DECIM - 1));
   assign ack_ok        = vga_req & vga_ack;
   assign at_right_edge = (vga_xCoord == 10'(H_RES - 1));
   // DRAW1 is entered on the transfer edge itself, before y1_q holds the new row.
   assign y1_nxt        = plot ? row1 : y1_q;

`ifdef PLOT_ERASE_EN
   logic        first_pass;
   logic [9:0]  rd_addr;
   logic [17:0] row_mem [H_RES];

   assign prev_rows = row_mem[rd_addr];

   always_ff @(posedge CLOCK_50)
      if (state == ST_ADVANCE)
         row_mem[vga_xCoord] <= {y1_q, y2_q};
`else
   assign prev_rows = '0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:
            if (plot) begin
`ifdef PLOT_ERASE_EN
               state_nxt = first_pass ? ST_DRAW1 : ST_ERASE1;
`else
               state_nxt = ST_DRAW1;
`endif
            end
         ST_ERASE1:  if (ack_ok) state_nxt = ST_ERASE2;
         ST_ERASE2:  if (ack_ok) state_nxt = ST_DRAW1;
         ST_DRAW1:   if (ack_ok) state_nxt = ST_DRAW2;
         ST_DRAW2:   if (ack_ok) state_nxt = ST_ADVANCE;
         ST_ADVANCE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         dec_cnt    <= '0;
         smp_ready  <= 1'b0;
         vga_req    <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_color  <= '0;
         vga_xCoord <= '0;
         y1_q       <= '0;
         y2_q       <= '0;
`ifdef PLOT_ERASE_EN
         first_pass <= 1'b1;
         rd_addr    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         smp_ready <= (state_nxt == ST_IDLE);
         vga_req   <= state_nxt inside {ST_ERASE1, ST_ERASE2, ST_DRAW1, ST_DRAW2};

         if (xfer)
            dec_cnt <= plot ? '0 : dec_cnt + 10'd1;
         if (plot) begin
            y1_q <= row1;
            y2_q <= row2;
         end

         // Pixel outputs are loaded on entry to each write state and simply re-loaded while stalled.
         case (state_nxt)
            ST_ERASE1: begin
               vga_x     <= vga_xCoord;
               vga_y     <= prev_rows[17:9];
               vga_color <= COLOR_BG;
            end
            ST_ERASE2: begin
               vga_x     <= vga_xCoord;
               vga_y     <= prev_rows[8:0];
               vga_color <= COLOR_BG;
            end
            ST_DRAW1: begin
               vga_x     <= vga_xCoord;
               vga_y     <= y1_nxt;
               vga_color <= COLOR1;
            end
            ST_DRAW2: begin
               vga_x     <= vga_xCoord;
               vga_y     <= y2_q;
               vga_color <= COLOR2;
            end
            default: ;
         endcase

         if (state == ST_ADVANCE) begin
            vga_xCoord <= at_right_edge ? 10'd0 : vga_xCoord + 10'd1;
`ifdef PLOT_ERASE_EN
            rd_addr    <= at_right_edge ? 10'd0 : vga_xCoord + 10'd1;
            if (at_right_edge)
               first_pass <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_osc_trace_plotter.sv
// tb/tb_osc_trace_plotter.sv - self-checking bench for osc_trace_plotter at DECIM=4, honours PLOT_ERASE_EN
module tb_osc_trace_plotter;

   localparam int DEC  = 4;
   localparam int HRES = 640;
   localparam int VRES = 480;
   localparam int YC   = 240;
   localparam int UNIT = 512;
`ifdef PLOT_ERASE_EN
   localparam bit ERASE = 1'b1;
`else
   localparam bit ERASE = 1'b0;
`endif

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [7:0] c;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        smp_valid;
   logic        smp_ready;
   logic [17:0] x1, x2;
   logic        vga_req, vga_ack;
   logic [9:0]  vga_x, vga_xCoord;
   logic [8:0]  vga_y;
   logic [7:0]  vga_color;

   osc_trace_plotter #(.DECIM(DEC)) dut (
      .CLOCK_50   (clk),
      .reset      (rst),
      .smp_valid  (smp_valid),
      .smp_ready  (smp_ready),
      .x1         (x1),
      .x2         (x2),
      .vga_req    (vga_req),
      .vga_ack    (vga_ack),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_color  (vga_color),
      .vga_xCoord (vga_xCoord)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   pix_t exp_q[$];
   pix_t got_q[$];
   int   m_dec, m_col;
   bit   m_first;
   int   m_r1[HRES];
   int   m_r2[HRES];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Floor division by the pixel scale, then centre and clamp.
   function automatic int exp_row(input logic signed [17:0] x);
      int v, t, r;
      v = int'(x);
      if (v >= 0) t = v / UNIT;
      else        t = -((-v + UNIT - 1) / UNIT);
      r = YC - t;
      if (r < 0) r = 0;
      if (r > VRES - 1) r = VRES - 1;
      return r;
   endfunction

   function automatic pix_t mk(input int x, input int y, input logic [7:0] c);
      pix_t p;
      p.x = 10'(x);
      p.y = 9'(y);
      p.c = c;
      return p;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_dec   = 0;
      m_col   = 0;
      m_first = 1'b1;
   endtask

   task automatic model_accept(input logic [17:0] a, input logic [17:0] b);
      int r1, r2;
      if (m_dec != DEC - 1) begin
         m_dec++;
         return;
      end
      m_dec = 0;
      r1 = exp_row(a);
      r2 = exp_row(b);
      if (ERASE && !m_first) begin
         exp_q.push_back(mk(m_col, m_r1[m_col], 8'h00));
         exp_q.push_back(mk(m_col, m_r2[m_col], 8'h00));
      end
      exp_q.push_back(mk(m_col, r1, 8'hE0));
      exp_q.push_back(mk(m_col, r2, 8'h1C));
      m_r1[m_col] = r1;
      m_r2[m_col] = r2;
      if (m_col == HRES - 1) begin
         m_col   = 0;
         m_first = 1'b0;
      end else begin
         m_col++;
      end
   endtask

   pix_t prev_pix;
   bit   prev_stall = 1'b0;

   always @(negedge clk) begin
      pix_t cur;
      pix_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         cur = {vga_x, vga_y, vga_color};
         if (vga_req) chk("ready_low_during_write", 32'(smp_ready), 32'(0));
         if (prev_stall && vga_req) chk("write_hold_stable", 32'(cur), 32'(prev_pix));
         if (vga_req && vga_ack) begin
            got_q.push_back(cur);
            if (exp_q.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               e = exp_q.pop_front();
               chk("pixel_write", 32'(cur), 32'(e));
            end
         end
         prev_stall = vga_req && !vga_ack;
         prev_pix   = cur;
         if (smp_valid && smp_ready) model_accept(x1, x2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [17:0] a, input logic [17:0] b);
      int n = 0;
      x1 = a;
      x2 = b;
      smp_valid = 1'b1;
      while (!smp_ready && n < 200) begin
         tick();
         n++;
      end
      if (!smp_ready) fail_now("send_timeout");
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic plot(input logic [17:0] a, input logic [17:0] b);
      for (int k = 0; k < DEC; k++) send(a, b);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || vga_req || !smp_ready) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail_now("idle_timeout");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      pix_t snap;
      rst       = 1'b1;
      smp_valid = 1'b0;
      x1        = '0;
      x2        = '0;
      vga_ack   = 1'b1;
      model_reset();
      #1;
      chk("reset_smp_ready", 32'(smp_ready), 32'(0));
      chk("reset_vga_req", 32'(vga_req), 32'(0));
      chk("reset_pixel", 32'({vga_x, vga_y, vga_color}), 32'(0));
      chk("reset_xcoord", 32'(vga_xCoord), 32'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("ready_after_reset", 32'(smp_ready), 32'(1));

      // mapping: -0.5 and +0.5
      got_q.delete();
      plot(18'h3_8000, 18'h0_8000);
      chk("latency_req_after_transfer", 32'(vga_req), 32'(1));
      wait_idle();
      chk("map_draw1", 32'(got_q[0]), 32'(mk(0, 304, 8'hE0)));
      chk("map_draw2", 32'(got_q[1]), 32'(mk(0, 176, 8'h1C)));

      // saturation at both rails
      got_q.delete();
      plot(18'h1_FFFF, 18'h2_0000);
      wait_idle();
      chk("sat_top", 32'(got_q[0]), 32'(mk(1, 0, 8'hE0)));
      chk("sat_bottom", 32'(got_q[1]), 32'(mk(1, 479, 8'h1C)));

      // handshake stall in DRAW1
      vga_ack = 1'b0;
      plot(18'h0_4000, 18'h3_C000);
      snap = {vga_x, vga_y, vga_color};
      chk("stall_first_pixel", 32'(snap), 32'(mk(2, 208, 8'hE0)));
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("stall_req", 32'(vga_req), 32'(1));
         chk("stall_pixel", 32'({vga_x, vga_y, vga_color}), 32'(snap));
         chk("stall_ready", 32'(smp_ready), 32'(0));
      end
      vga_ack = 1'b1;
      tick();
      vga_ack = 1'b0;
      chk("one_ack_to_draw2", 32'({vga_x, vga_y, vga_color}), 32'(mk(2, 272, 8'h1C)));
      vga_ack = 1'b1;
      wait_idle();

      // decimation: 12 back-to-back samples -> 3 columns
      do_reset();
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         if (i % DEC != 0) chk("no_bubble_on_skip", 32'(smp_ready), 32'(1));
         send(18'(i * 4096), 18'(-i * 4096));
      end
      wait_idle();
      chk("decim_write_count", 32'(got_q.size()), 32'(6));
      chk("decim_col0", 32'(got_q[0].x), 32'(0));
      chk("decim_col1", 32'(got_q[2].x), 32'(1));
      chk("decim_col2", 32'(got_q[4].x), 32'(2));
      chk("decim_col0_row", 32'(got_q[0].y), 32'(216));
      chk("decim_xcoord", 32'(vga_xCoord), 32'(3));

      // wrap: 638 more plotted samples -> columns 3..639 then 0
      got_q.delete();
      for (int p = 0; p < 638; p++)
         plot(18'(p * 1237), 18'(5 - p * 911));
      wait_idle();
      chk("wrap_xcoord", 32'(vga_xCoord), 32'(1));
      chk("wrap_last_draw", 32'(got_q[got_q.size() - 1].x), 32'(0));
      chk("wrap_last_color", 32'(got_q[got_q.size() - 1].c), 32'(8'h1C));
`ifdef PLOT_ERASE_EN
      chk("wrap_erase1", 32'(got_q[got_q.size() - 4]), 32'(mk(0, 216, 8'h00)));
      chk("wrap_erase2", 32'(got_q[got_q.size() - 3]), 32'(mk(0, 264, 8'h00)));
`endif

      // async reset in the second write of a plotted sample
      vga_ack = 1'b0;
      plot(18'h0_2000, 18'h3_E000);
      vga_ack = 1'b1;
      tick();
      vga_ack = 1'b0;
      chk("pre_reset_req", 32'(vga_req), 32'(1));
      #2;
      rst = 1'b1;
      #1;
      chk("reset_drops_req", 32'(vga_req), 32'(0));
      chk("reset_xcoord_mid", 32'(vga_xCoord), 32'(0));
      model_reset();
      tick();
      tick();
      rst     = 1'b0;
      vga_ack = 1'b1;
      tick();
      got_q.delete();
      plot(18'h0_0000, 18'h0_0000);
      wait_idle();
      chk("post_reset_writes", 32'(got_q.size()), 32'(2));
      chk("post_reset_draw1", 32'(got_q[0]), 32'(mk(0, 240, 8'hE0)));

      chk("expect_queue_drained", 32'(exp_q.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/osc_trace_plotter.md
Name: osc_trace_plotter

Overview:
- Sink for the sample stream produced by the Euler coupled-oscillator datapath (x1, x2 in signed 2.16 fixed point).
- Converts each plotted sample to two screen rows and issues single-pixel writes to the VGA pixel-write port of the video memory arbiter.
- Scrolls a column cursor across the screen, wrapping at the right edge.
- With erase enabled, it first repaints the pixels drawn in that column on the previous pass before drawing new ones.

Parameters:
- H_RES, 640, columns; the cursor wraps at H_RES-1.
- V_RES, 480, rows; row results saturate to 0..V_RES-1.
- Y_CENTER, 240, row for value 0.0.
- Y_GAIN_LOG2, 7, pixels per unit = 2^Y_GAIN_LOG2.
- DECIM, 1, plot one of every DECIM accepted samples (1..1024).
- COLOR1, 8'hE0, colour for x1.
- COLOR2, 8'h1C, colour for x2.
- COLOR_BG, 8'h00, background colour used for erase.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high
- smp_valid  in  1  oscillator sample valid
- smp_ready  out  1  plotter can accept a sample
- x1  in  18  signed 2.16 position of mass 1
- x2  in  18  signed 2.16 position of mass 2
- vga_req  out  1  pixel write request
- vga_ack  in  1  arbiter accepted the write this cycle
- vga_x  out  10  pixel column
- vga_y  out  9  pixel row
- vga_color  out  8  pixel colour (RGB332)
- vga_xCoord  out  10  current cursor column

Behaviour:
- Reset (async, active-high) forces:
  - smp_ready=0, vga_req=0, vga_x=0, vga_y=0, vga_color=0, vga_xCoord=0
  - state=IDLE, decimation count=0, first_pass=1
  - Row memory contents are not cleared.
- Reset asserted mid-write drops vga_req immediately. The arbiter must tolerate an abandoned request.
- States: IDLE, ERASE1, ERASE2, DRAW1, DRAW2, ADVANCE.
- IDLE:
  - smp_ready=1 registered; in all other states it is 0.
  - A sample transfers on smp_valid & smp_ready.
  - On transfer: if dec_cnt != DECIM-1, increment dec_cnt and stay in IDLE (sample dropped, no bubble).
  - Otherwise set dec_cnt=0, latch y1/y2 rows, and go to ERASE1. If first_pass=1, go straight to DRAW1.
- Row mapping, per coordinate:
  - t = x >>> (16 - Y_GAIN_LOG2), arithmetic shift, truncating toward -inf.
  - row = Y_CENTER - t, computed at 12 bits signed.
  - Clamp: row<0 -> 0; row>V_RES-1 -> V_RES-1.
- Write cycles:
  - ERASE1/2 write COLOR_BG at (vga_xCoord, prev_y1/prev_y2) read from the row memory.
  - DRAW1 writes COLOR1 at (vga_xCoord, y1); DRAW2 writes COLOR2 at (vga_xCoord, y2).
  - In each write state, vga_req=1 with vga_x/y/color stable until the cycle vga_ack=1. The state advances on the next edge.
  - vga_ack while vga_req=0 is ignored.
  - Back-to-back writes are allowed: minimum one cycle per pixel when vga_ack is tied high.
- Ordering: erase precedes draw, so a new pixel that coincides with an old one survives. When y1==y2, DRAW2 wins (COLOR2 visible).
- ADVANCE:
  - Write y1/y2 into the row memory at vga_xCoord.
  - If vga_xCoord==H_RES-1, set vga_xCoord=0 and first_pass=0; else increment.
  - Return to IDLE.
- Latency: transfer edge -> vga_req asserted on the following cycle.
- Throughput with vga_ack tied high: one plotted sample per 6 cycles (IDLE + 4 writes + ADVANCE).

Optional Feature:
- PLOT_ERASE_EN defined:
  - Row memory present: H_RES x 18 bits {prev_y1, prev_y2}, inferred synchronous RAM, read-address registered on entry to IDLE.
  - ERASE states active after the first pass.
- PLOT_ERASE_EN undefined:
  - No row memory, no first_pass flag, and ERASE1/ERASE2 are unreachable. IDLE goes directly to DRAW1, giving persistent traces.
  - Throughput is one sample per 4 cycles.

Decomposition:
- Package osc_plot_pkg holds:
  - the fixed-point width constant (18) and fraction bits (16)
  - the plot_state_t enum
  - screen-size defaults
  - RGB332 colour constants
- One sub-module, fix_to_row: combinational shift, offset and saturate. It is instantiated twice (x1, x2).

Test Plan:
- Mapping: x1=18'h3_8000 (-0.5), x2=18'h0_8000 (+0.5), vga_ack=1 -> DRAW1 at y=304 with 8'hE0, DRAW2 at y=176 with 8'h1C, x=0.
- Saturation: x1=18'h1_FFFF (~+2.0), x2=18'h2_0000 (-2.0) -> y1=0, y2=479.
- Handshake: hold vga_ack=0 for 7 cycles in DRAW1 -> vga_req/x/y/color stable; smp_ready=0; no state change. A single ack cycle moves to DRAW2.
- Decimation: DECIM=4, 12 back-to-back valid samples -> smp_ready continuously high on skipped samples; exactly 3 columns drawn (x=0,1,2).
- Wrap/erase (PLOT_ERASE_EN): 641 plotted samples -> column 639 then 0. Sample 641 produces BG writes at the rows stored for column 0, then new draws; first_pass clears.
- Async reset asserted mid-ERASE2 -> vga_req low in the same cycle, vga_xCoord=0. The next sample draws without erase.
